// File: rtl/tt_um_jleugeri_ticktocktokens_sequencer_if.sv
// Event stream from the run sequencer to its consumer.
// Each transfer carries one nonzero start/stop code of one processor.
interface tt_um_jleugeri_ticktocktokens_sequencer_if #(
    parameter int ID_BITS   = 4,
    parameter int TICK_BITS = 8
);
    logic                 ev_valid;
    logic                 ev_ready;
    logic [ID_BITS-1:0]   ev_id;
    logic [1:0]           ev_code;
    logic [TICK_BITS-1:0] ev_tick;

    modport master (
        output ev_valid,
        output ev_id,
        output ev_code,
        output ev_tick,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_id,
        input  ev_code,
        input  ev_tick,
        output ev_ready
    );
endinterface

// File: rtl/tt_um_jleugeri_ticktocktokens_sequencer.sv
// Run controller for the ticktocktokens datapath: steps slow ticks,
// then scans every processor and streams its nonzero start/stop code.
module tt_um_jleugeri_ticktocktokens_sequencer #(
    parameter int NUM_PROCESSORS = 10,
    parameter int ID_BITS        = $clog2(NUM_PROCESSORS),
    parameter int TICK_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_req,
    input  logic [TICK_BITS-1:0] tick_count,
    input  logic                 abort,
    output logic                 run_busy,
    output logic                 run_done,
    output logic                 timeout_err,
    output logic                 hold,
    output logic                 tick,
    input  logic                 main_done,
    output logic [ID_BITS-1:0]   processor_id,
    input  logic [1:0]           token_startstop,
    tt_um_jleugeri_ticktocktokens_sequencer_if.master ev
);
    localparam int WAIT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_BITS-1:0] WAIT_LAST =
        WAIT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_BITS-1:0] ID_LAST =
        ID_BITS'(NUM_PROCESSORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TICK,
        S_WAIT,
        S_SCAN,
        S_SAMPLE,
        S_EMIT,
        S_NEXT
    } state_t;

    state_t               state_q;
    logic [TICK_BITS-1:0] remaining_q;
    logic [TICK_BITS-1:0] tick_idx_q;
    logic [WAIT_BITS-1:0] wait_q;
    logic [ID_BITS-1:0]   scan_q;
    logic [ID_BITS-1:0]   pid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 terr_q;
    logic                 hold_q;
    logic                 tick_q;
    logic                 ev_valid_q;
    logic [ID_BITS-1:0]   ev_id_q;
    logic [1:0]           ev_code_q;
    logic [TICK_BITS-1:0] ev_tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            tick_idx_q  <= '0;
            wait_q      <= '0;
            scan_q      <= '0;
            pid_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
            hold_q      <= 1'b1;
            tick_q      <= 1'b0;
            ev_valid_q  <= 1'b0;
            ev_id_q     <= '0;
            ev_code_q   <= 2'b00;
            ev_tick_q   <= '0;
        end else begin
            done_q <= 1'b0;
            tick_q <= 1'b0;
            if (abort && state_q != S_IDLE) begin
                state_q    <= S_IDLE;
                hold_q     <= 1'b1;
                ev_valid_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (run_req && tick_count != '0) begin
                            remaining_q <= tick_count;
                            tick_idx_q  <= '0;
                            terr_q      <= 1'b0;
                            busy_q      <= 1'b1;
                            hold_q      <= 1'b0;
                            tick_q      <= 1'b1;
                            state_q     <= S_TICK;
                        end else if (run_req) begin
                            done_q <= 1'b1;
                        end
                    end
                    S_TICK: begin
                        wait_q  <= '0;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (main_done) begin
                            scan_q  <= '0;
                            pid_q   <= '0;
                            hold_q  <= 1'b1;
                            state_q <= S_SCAN;
                        end else if (wait_q == WAIT_LAST) begin
                            terr_q  <= 1'b1;
                            hold_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            wait_q <= wait_q + 1'b1;
                        end
                    end
                    // processor_id settles for one cycle before sampling
                    S_SCAN: state_q <= S_SAMPLE;
                    S_SAMPLE: begin
                        if (token_startstop != 2'b00) begin
                            ev_id_q    <= scan_q;
                            ev_code_q  <= token_startstop;
                            ev_tick_q  <= tick_idx_q;
                            ev_valid_q <= 1'b1;
                            state_q    <= S_EMIT;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end
                    S_EMIT: begin
                        if (ev.ev_ready) begin
                            ev_valid_q <= 1'b0;
                            state_q    <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (scan_q != ID_LAST) begin
                            scan_q  <= scan_q + 1'b1;
                            pid_q   <= scan_q + 1'b1;
                            state_q <= S_SCAN;
                        end else if (remaining_q == TICK_BITS'(1)) begin
                            remaining_q <= '0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            remaining_q <= remaining_q - 1'b1;
                            tick_idx_q  <= tick_idx_q + 1'b1;
                            hold_q      <= 1'b0;
                            tick_q      <= 1'b1;
                            state_q     <= S_TICK;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign run_busy     = busy_q;
    assign run_done     = done_q;
    assign timeout_err  = terr_q;
    assign hold         = hold_q;
    assign tick         = tick_q;
    assign processor_id = pid_q;
    assign ev.ev_valid  = ev_valid_q;
    assign ev.ev_id     = ev_id_q;
    assign ev.ev_code   = ev_code_q;
    assign ev.ev_tick   = ev_tick_q;
endmodule
